// File: rtl/isp_pkg.sv
// isp_pkg: shared pixel-stream widths and the calibration FSM state type
package isp_pkg;
  localparam int PIX_W = 10;
  localparam int LANES = 4;
  localparam int TDATA_W = PIX_W * LANES;
  typedef enum logic [1:0] {IDLE, ACC, WAIT} blc_state_e;
endpackage

// File: rtl/blc_chan_acc.sv
// blc_chan_acc: per-channel sample accumulator with rounded, saturated mean
module blc_chan_acc
  import isp_pkg::*;
#(
  parameter int S = 3
) (
  input  logic             I_clk,
  input  logic             I_rst,
  input  logic             I_clear,
  input  logic             I_add,
  input  logic [PIX_W-1:0] I_a,
  input  logic [PIX_W-1:0] I_b,
  output logic [PIX_W-1:0] O_mean
);
  localparam int AW = PIX_W + S;
  localparam int RND = (S > 0) ? (1 << (S - 1)) : 0;
  logic [AW-1:0] acc, acc_nxt;
  logic [AW:0] rnd_sum;
  logic [PIX_W:0] q;
  // The mean is taken from the next accumulator value so the final beat is included
  always_comb begin
    acc_nxt = (I_clear ? '0 : acc) + (I_add ? AW'(I_a) + AW'(I_b) : '0);
    rnd_sum = {1'b0, acc_nxt} + (AW + 1)'(RND);
    q = rnd_sum[AW:S];
    O_mean = q[PIX_W] ? '1 : q[PIX_W-1:0];
  end
  always_ff @(posedge I_clk) begin
    if (I_rst) acc <= '0;
    else acc <= acc_nxt;
  end
endmodule

// File: rtl/blc_level_estimator.sv
// blc_level_estimator: per-Bayer-channel black level from leading OB rows, with stream register slice
module blc_level_estimator
  import isp_pkg::*;
#(
  parameter int OB_ROWS_LOG2 = 1,
  parameter int H_BEATS_LOG2 = 6,
  parameter logic [PIX_W-1:0] DEFAULT_OFFSET = 10'd15
) (
  input  logic               I_clk,
  input  logic               I_rst,
  input  logic               I_cal_en,
  input  logic [TDATA_W-1:0] I_tdata,
  input  logic               I_tvalid,
  input  logic               I_tuser,
  input  logic               I_tlast,
  output logic               I_tready,
  output logic [TDATA_W-1:0] O_tdata,
  output logic               O_tvalid,
  output logic               O_tuser,
  output logic               O_tlast,
  input  logic               O_tready,
  output logic [PIX_W-1:0]   O_blc_r0,
  output logic [PIX_W-1:0]   O_blc_r1,
  output logic [PIX_W-1:0]   O_blc_r2,
  output logic [PIX_W-1:0]   O_blc_r3,
  output logic               O_blc_valid,
  output logic               O_err
);
  localparam int S = OB_ROWS_LOG2 + H_BEATS_LOG2;
  localparam logic [H_BEATS_LOG2:0] H_LAST = (H_BEATS_LOG2 + 1)'((1 << H_BEATS_LOG2) - 1);
  localparam logic [OB_ROWS_LOG2:0] R_LAST = (OB_ROWS_LOG2 + 1)'((1 << OB_ROWS_LOG2) - 1);
  blc_state_e state;
  logic [H_BEATS_LOG2:0] beat_cnt, bc;
  logic [OB_ROWS_LOG2:0] row_cnt, rc;
  logic accept, start, step, row_end, len_err;
  logic [PIX_W-1:0] mean [4];
  assign I_tready = O_tready || !O_tvalid;
  // A SOF beat always counts as row 0 beat 0, whatever the counters held
  always_comb begin
    accept = I_tvalid && I_tready;
    start = accept && I_cal_en && I_tuser;
    step = start || (accept && I_cal_en && state == ACC);
    bc = start ? '0 : beat_cnt;
    rc = start ? '0 : row_cnt;
    row_end = I_tlast && bc == H_LAST;
    len_err = I_tlast != (bc == H_LAST);
  end
  for (genvar g = 0; g < 4; g++) begin : g_ch
    blc_chan_acc #(.S(S)) u_acc (
      .I_clk  (I_clk),
      .I_rst  (I_rst),
      .I_clear(start || !I_cal_en),
      .I_add  (step && (rc[0] == (g >= 2))),
      .I_a    (I_tdata[(g % 2) * PIX_W +: PIX_W]),
      .I_b    (I_tdata[(g % 2 + 2) * PIX_W +: PIX_W]),
      .O_mean (mean[g])
    );
  end
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state <= IDLE;
      beat_cnt <= '0;
      row_cnt <= '0;
      O_blc_valid <= 1'b0;
      O_err <= 1'b0;
      O_blc_r0 <= DEFAULT_OFFSET;
      O_blc_r1 <= DEFAULT_OFFSET;
      O_blc_r2 <= DEFAULT_OFFSET;
      O_blc_r3 <= DEFAULT_OFFSET;
    end else begin
      O_blc_valid <= 1'b0;
      O_err <= 1'b0;
      if (!I_cal_en) state <= IDLE;
      else if (step) begin
        O_err <= len_err || (start && state == ACC);
        beat_cnt <= row_end ? '0 : bc + 1'b1;
        row_cnt <= row_end ? rc + 1'b1 : rc;
        if (len_err) state <= WAIT;
        else if (row_end && rc == R_LAST) begin
          state <= WAIT;
          O_blc_valid <= 1'b1;
          O_blc_r0 <= mean[0];
          O_blc_r1 <= mean[1];
          O_blc_r2 <= mean[2];
          O_blc_r3 <= mean[3];
        end else state <= ACC;
      end
    end
  end
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      O_tvalid <= 1'b0;
      O_tuser <= 1'b0;
      O_tlast <= 1'b0;
      O_tdata <= '0;
    end else if (accept) begin
      O_tvalid <= 1'b1;
      O_tuser <= I_tuser;
      O_tlast <= I_tlast;
      O_tdata <= I_tdata;
    end else if (O_tready) O_tvalid <= 1'b0;
  end
endmodule

// File: tb/tb_blc_level_estimator.sv
// tb_blc_level_estimator: randomized scoreboard bench with a frame-level reference model
module tb_blc_level_estimator;
  localparam int H = 4;
  localparam int NB = 8;
  localparam int S = 3;
  localparam logic [39:0] EV = {10'd23, 10'd22, 10'd21, 10'd20};
  localparam logic [39:0] OD = {10'd27, 10'd26, 10'd25, 10'd24};
  localparam logic [39:0] P16 = {4{10'd16}};
  localparam logic [39:0] CONST_R = {10'd26, 10'd25, 10'd22, 10'd21};
  typedef struct packed {logic [39:0] d; logic u; logic l;} beat_t;
  typedef struct packed {logic err; logic [39:0] r;} ev_t;

  logic I_clk = 0, I_rst = 1, I_cal_en = 0, I_tvalid = 0, I_tuser = 0, I_tlast = 0, O_tready = 1;
  logic [39:0] I_tdata = '0;
  logic I_tready, O_tvalid, O_tuser, O_tlast, O_blc_valid, O_err;
  logic [39:0] O_tdata;
  logic [9:0] O_blc_r0, O_blc_r1, O_blc_r2, O_blc_r3;

  beat_t sq[$];
  ev_t eq[$];
  logic [39:0] cur[$];
  bit active, stalled, in_rst = 1;
  beat_t held, mb;
  ev_t me;
  logic [39:0] exp_r = {4{10'd15}};
  int checks, errors, rdy_mode, rdy_cnt;

  blc_level_estimator #(.OB_ROWS_LOG2(1), .H_BEATS_LOG2(2), .DEFAULT_OFFSET(10'd15)) dut (
    .I_clk(I_clk), .I_rst(I_rst), .I_cal_en(I_cal_en), .I_tdata(I_tdata), .I_tvalid(I_tvalid),
    .I_tuser(I_tuser), .I_tlast(I_tlast), .I_tready(I_tready), .O_tdata(O_tdata), .O_tvalid(O_tvalid),
    .O_tuser(O_tuser), .O_tlast(O_tlast), .O_tready(O_tready), .O_blc_r0(O_blc_r0), .O_blc_r1(O_blc_r1),
    .O_blc_r2(O_blc_r2), .O_blc_r3(O_blc_r3), .O_blc_valid(O_blc_valid), .O_err(O_err)
  );

  always #5 I_clk = ~I_clk;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_levels(string name, logic [39:0] exp);
    chk(name, {O_blc_r3, O_blc_r2, O_blc_r1, O_blc_r0}, exp);
  endtask

  // Reference: a measurement is the NB beats following a SOF; beat i of it must carry tlast
  // exactly when it ends a row, channel = {row parity, lane parity}
  function automatic logic [39:0] means();
    logic [39:0] r;
    int sum;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      sum = 0;
      for (int j = 0; j < cur.size(); j++)
        if ((j / H) % 2 == c / 2) sum += int'(cur[j][(c % 2) * 10 +: 10]) + int'(cur[j][(c % 2 + 2) * 10 +: 10]);
      sum = (sum + (1 << (S - 1))) >> S;
      if (sum > 1023) sum = 1023;
      r[c * 10 +: 10] = 10'(sum);
    end
    return r;
  endfunction

  task automatic model_beat(logic [39:0] d, bit u, bit l);
    bit err;
    int i;
    err = 0;
    if (!I_cal_en) begin
      active = 0;
      return;
    end
    if (u) begin
      err = active;
      cur.delete();
      active = 1;
    end
    if (!active) return;
    cur.push_back(d);
    i = cur.size() - 1;
    if (l != (i % H == H - 1)) begin
      err = 1;
      active = 0;
    end
    if (err) eq.push_back(ev_t'{1'b1, 40'd0});
    else if (cur.size() == NB) begin
      eq.push_back(ev_t'{1'b0, means()});
      active = 0;
    end
  endtask

  task automatic send(logic [39:0] d, bit u, bit l, int gap);
    bit ok;
    ok = 0;
    repeat (gap) begin
      @(posedge I_clk);
      #1;
    end
    I_tdata = d;
    I_tuser = u;
    I_tlast = l;
    I_tvalid = 1;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge I_clk);
      ok = I_tready;
      @(posedge I_clk);
      #1;
    end
    I_tvalid = 0;
    chk("accept_timeout", ok, 1);
    if (!ok) return;
    chk("latency", {O_tvalid, O_tdata, O_tuser, O_tlast}, {1'b1, d, u, l});
    sq.push_back({d, u, l});
    model_beat(d, u, l);
  endtask

  task automatic send_row(logic [39:0] d, bit sof, int gmax);
    for (int b = 0; b < H; b++) send(d, sof && b == 0, b == H - 1, $urandom_range(0, gmax));
  endtask

  task automatic send_frame(logic [39:0] ev, logic [39:0] od, int gmax);
    for (int r = 0; r < 4; r++) send_row(r % 2 ? od : ev, r == 0, gmax);
  endtask

  task automatic do_reset();
    in_rst = 1;
    I_rst = 1;
    I_tvalid = 0;
    @(posedge I_clk);
    #1;
    I_rst = 0;
    sq.delete();
    eq.delete();
    cur.delete();
    active = 0;
    stalled = 0;
    exp_r = {4{10'd15}};
    in_rst = 0;
  endtask

  task automatic set_cal(bit v);
    I_cal_en = v;
    if (!v) active = 0;
  endtask

  initial forever begin
    @(posedge I_clk);
    #1;
    rdy_cnt++;
    O_tready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? (rdy_cnt % 4 == 0 || rdy_cnt % 4 == 3) : ($urandom_range(0, 2) != 0);
  end

  initial forever begin
    @(negedge I_clk);
    if (!in_rst) begin
      if (stalled) chk("stall_hold", {O_tvalid, O_tdata, O_tuser, O_tlast}, {1'b1, held});
      if (!I_tready) chk("tready_drop", {O_tvalid, O_tready}, 2'b10);
      if (O_tvalid && O_tready) begin
        if (sq.size() == 0) chk("stream_extra", 1, 0);
        else begin
          mb = sq.pop_front();
          chk("stream", {O_tdata, O_tuser, O_tlast}, mb);
        end
      end
      stalled = O_tvalid && !O_tready;
      held = {O_tdata, O_tuser, O_tlast};
      if (O_blc_valid || O_err) begin
        if (eq.size() == 0) chk("event_extra", {O_blc_valid, O_err}, 0);
        else begin
          me = eq.pop_front();
          chk("event_kind", {O_blc_valid, O_err}, me.err ? 2'b01 : 2'b10);
          if (!me.err) exp_r = me.r;
        end
      end else if (eq.size() != 0) begin
        me = eq.pop_front();
        chk("event_missing", {O_blc_valid, O_err}, me.err ? 2'b01 : 2'b10);
      end
      chk_levels("levels", exp_r);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int fault, fr, fb;
    logic [39:0] d;
    @(posedge I_clk);
    #1;
    do_reset();
    chk_levels("reset_levels", {4{10'd15}});
    chk("reset_stream", {O_tvalid, O_tuser, O_tlast, O_tdata, I_tready}, {3'b000, 40'd0, 1'b1});
    chk("reset_pulses", {O_blc_valid, O_err}, 0);
    set_cal(1);
    send_frame(EV, OD, 0);
    chk_levels("const_means", CONST_R);
    for (int v = 20; v >= 19; v--) begin
      send({P16[39:10], 10'(v)}, 1, 0, 0);
      for (int b = 1; b < H; b++) send(P16, 0, b == H - 1, 0);
      for (int r = 1; r < 4; r++) send_row(P16, 0, 0);
      chk_levels(v == 20 ? "round_up" : "round_down", {30'({3{10'd16}}), v == 20 ? 10'd17 : 10'd16});
    end
    send(EV, 1, 0, 0);
    send(EV, 0, 0, 0);
    send(EV, 0, 1, 0);
    chk("short_err", O_err, 1);
    for (int r = 1; r < 4; r++) send_row(r % 2 ? OD : EV, 0, 1);
    chk_levels("short_hold", {4{10'd16}});
    send_frame(EV, OD, 1);
    chk_levels("after_short", CONST_R);
    send_row(EV, 1, 0);
    send(OD, 0, 0, 0);
    send({10'd33, 10'd32, 10'd31, 10'd30}, 1, 0, 0);
    chk("sof_mid_err", O_err, 1);
    for (int b = 1; b < H; b++) send({10'd33, 10'd32, 10'd31, 10'd30}, 0, b == H - 1, 0);
    send_row({10'd43, 10'd42, 10'd41, 10'd40}, 0, 0);
    chk_levels("sof_mid_means", {10'd42, 10'd41, 10'd32, 10'd31});
    rdy_mode = 1;
    send_frame(EV, OD, 0);
    chk_levels("bp_means", CONST_R);
    rdy_mode = 0;
    repeat (3) @(posedge I_clk);
    #1;
    send_row(P16, 1, 0);
    send(P16, 0, 0, 0);
    do_reset();
    chk_levels("rst_levels", {4{10'd15}});
    chk("rst_stream", {O_tvalid, O_tdata, I_tready, O_blc_valid, O_err}, {1'b0, 40'd0, 1'b1, 2'b00});
    for (int b = 1; b < H; b++) send(P16, 0, b == H - 1, 0);
    for (int r = 2; r < 4; r++) send_row(P16, 0, 0);
    chk_levels("rst_idle", {4{10'd15}});
    send_frame(EV, OD, 0);
    send_row(P16, 1, 0);
    set_cal(0);
    for (int r = 1; r < 4; r++) send_row(OD, 0, 0);
    send_frame(P16, P16, 0);
    chk_levels("cal_off_hold", CONST_R);
    set_cal(1);
    send_frame({10'd3, 10'd2, 10'd1, 10'd0}, {10'd7, 10'd6, 10'd5, 10'd4}, 0);
    chk_levels("cal_on_means", {10'd6, 10'd5, 10'd2, 10'd1});
    rdy_mode = 2;
    for (int f = 0; f < 40; f++) begin
      fault = $urandom_range(0, 5);
      fr = $urandom_range(0, 1);
      fb = $urandom_range(0, H - 1);
      for (int r = 0; r < 4; r++)
        for (int b = 0; b < H; b++) begin
          d[31:0] = $urandom;
          d[39:32] = 8'($urandom);
          if (f % 7 == 3) d = '1;
          send(d, (r == 0 && b == 0) || (fault == 5 && r == fr && b == fb),
               (b == H - 1) ^ (fault == 4 && r == fr && b == fb), $urandom_range(0, 2));
        end
    end
    rdy_mode = 0;
    repeat (6) @(posedge I_clk);
    #1;
    chk("stream_drained", sq.size(), 0);
    chk("events_drained", eq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
